// File: rtl/audio_filter_pkg.sv
// Shared types and default sizing for the audio filter effect stages.
package audio_filter_pkg;

    localparam int DATA_WIDTH_DEF = 12;
    localparam int COEF_WIDTH_DEF = 6;
    localparam int GUARD_BITS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE_S   = 2'd0,
        DIFF_S   = 2'd1,
        MUL_S    = 2'd2,
        UPDATE_S = 2'd3
    } filt_state_e;

endpackage

// File: rtl/serial_shift_add_multiplier.sv
// Signed x unsigned multiplier, one multiplier bit per cycle, LSB first.
// done_i is high during the final accumulate step; product_o is complete on the following cycle.
module serial_shift_add_multiplier #(
    parameter int McandWidth  = 17,
    parameter int MplierWidth = 6
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start_i,
    input  logic signed [McandWidth-1:0]              mcand_i,
    input  logic        [MplierWidth-1:0]             mplier_i,
    output logic                                      done_o,
    output logic signed [McandWidth+MplierWidth-1:0]  product_o
);
    localparam int AccWidth = McandWidth + MplierWidth;
    localparam int StepW    = (MplierWidth > 1) ? $clog2(MplierWidth) : 1;
    localparam logic [StepW-1:0] LastStep = StepW'(MplierWidth - 1);

    logic signed [AccWidth-1:0] mcand_q, mcand_d, acc_q, acc_d;
    logic [MplierWidth-1:0]     mplier_q, mplier_d;
    logic [StepW-1:0]           step_q, step_d;
    logic                       run_q, run_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        step_d   = step_q;
        run_d    = run_q;
        if (start_i) begin
            mcand_d  = {{MplierWidth{mcand_i[McandWidth-1]}}, mcand_i};
            mplier_d = mplier_i;
            acc_d    = '0;
            step_d   = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            // Multiplicand is pre-shifted each step, so bit 0 always selects mcand <<< step.
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q <<< 1;
            mplier_d = mplier_q >> 1;
            step_d   = step_q + StepW'(1);
            if (step_q == LastStep) run_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            step_q   <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            step_q   <= step_d;
            run_q    <= run_d;
        end
    end

    assign done_o    = run_q && (step_q == LastStep);
    assign product_o = acc_q;

endmodule

// File: rtl/audio_lowpass_filter.sv
// First-order IIR low-pass: y += alpha*(x - y), alpha = coef/2^CoefWidth, serial multiply.
// Optional AUDIO_LOWPASS_HIGHPASS_EN adds highpassSel to output the saturated x - lowpass.
module audio_lowpass_filter
    import audio_filter_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH_DEF,
    parameter int CoefWidth = COEF_WIDTH_DEF,
    parameter int GuardBits = GUARD_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CoefWidth-1:0] coef,
    input  logic [DataWidth-1:0] inData,
    input  logic                 inValid,
    input  logic                 clearOverrun,
`ifdef AUDIO_LOWPASS_HIGHPASS_EN
    input  logic                 highpassSel,
`endif
    output logic [DataWidth-1:0] outData,
    output logic                 outValid,
    output logic                 busy,
    output logic                 overrun
);
    localparam int YW    = DataWidth + GuardBits;
    localparam int DiffW = YW + 1;
    localparam int AccW  = DiffW + CoefWidth;

    filt_state_e state_q, state_d;
    logic signed [DataWidth-1:0] x_q, x_d, out_q, out_d, lp_out, res_out;
    logic signed [YW-1:0]        y_q, y_d, y_new;
    logic signed [DiffW-1:0]     diff;
    logic signed [AccW-1:0]      product, acc_sh;
    logic                        out_vld_q, out_vld_d, ovr_q, ovr_d, mul_done;
    logic                        unused_acc;

    assign diff   = $signed({x_q[DataWidth-1], x_q, {GuardBits{1'b0}}})
                  - $signed({y_q[YW-1], y_q});
    assign acc_sh = product >>> CoefWidth;
    // alpha < 1 keeps y_new between y and x<<G, so the upper bits carry only sign.
    assign y_new  = y_q + acc_sh[YW-1:0];
    assign lp_out = y_new[YW-1:GuardBits];
    assign unused_acc = ^acc_sh[AccW-1:YW];

    serial_shift_add_multiplier #(
        .McandWidth (DiffW),
        .MplierWidth(CoefWidth)
    ) u_mul (
        .clk      (clk),
        .reset    (reset),
        .start_i  (state_q == DIFF_S),
        .mcand_i  (diff),
        .mplier_i (coef),
        .done_o   (mul_done),
        .product_o(product)
    );

`ifdef AUDIO_LOWPASS_HIGHPASS_EN
    logic                    hp_q, hp_d;
    logic signed [DataWidth:0] hp_diff;

    assign hp_diff = $signed({x_q[DataWidth-1], x_q}) - $signed({lp_out[DataWidth-1], lp_out});

    always_comb begin
        res_out = lp_out;
        if (hp_q) begin
            if (hp_diff[DataWidth] != hp_diff[DataWidth-1])
                res_out = hp_diff[DataWidth] ? {1'b1, {(DataWidth-1){1'b0}}}
                                             : {1'b0, {(DataWidth-1){1'b1}}};
            else
                res_out = hp_diff[DataWidth-1:0];
        end
    end
`else
    assign res_out = lp_out;
`endif

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        out_d     = out_q;
        out_vld_d = 1'b0;
        ovr_d     = ovr_q;
`ifdef AUDIO_LOWPASS_HIGHPASS_EN
        hp_d      = hp_q;
`endif
        // Drop beats clear when both happen in one cycle.
        if (clearOverrun) ovr_d = 1'b0;
        if (inValid && state_q != IDLE_S) ovr_d = 1'b1;
        case (state_q)
            IDLE_S: begin
                if (inValid) begin
                    x_d     = inData;
                    state_d = DIFF_S;
                end
            end
            DIFF_S: begin
`ifdef AUDIO_LOWPASS_HIGHPASS_EN
                hp_d    = highpassSel;
`endif
                state_d = MUL_S;
            end
            MUL_S: begin
                if (mul_done) state_d = UPDATE_S;
            end
            UPDATE_S: begin
                y_d       = y_new;
                out_d     = res_out;
                out_vld_d = 1'b1;
                state_d   = IDLE_S;
            end
            default: state_d = IDLE_S;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE_S;
            x_q       <= '0;
            y_q       <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef AUDIO_LOWPASS_HIGHPASS_EN
            hp_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            ovr_q     <= ovr_d;
`ifdef AUDIO_LOWPASS_HIGHPASS_EN
            hp_q      <= hp_d;
`endif
        end
    end

    assign outData  = out_q;
    assign outValid = out_vld_q;
    assign busy     = (state_q != IDLE_S);
    assign overrun  = ovr_q;

endmodule

// File: tb/tb_audio_lowpass_filter.sv
// Scoreboard bench: a reference model pushes expected samples, a monitor pops on outValid.
module tb_audio_lowpass_filter;
    localparam int DW = 12;
    localparam int CW = 6;
    localparam int G  = 4;
    localparam int LAT = CW + 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] coef = '0;
    logic [DW-1:0] inData = '0;
    logic          inValid = 1'b0;
    logic          clearOverrun = 1'b0;
    logic          highpassSel = 1'b0;
    logic [DW-1:0] outData;
    logic          outValid, busy, overrun;

    audio_lowpass_filter dut (
        .clk         (clk),
        .reset       (reset),
        .coef        (coef),
        .inData      (inData),
        .inValid     (inValid),
        .clearOverrun(clearOverrun),
`ifdef AUDIO_LOWPASS_HIGHPASS_EN
        .highpassSel (highpassSel),
`endif
        .outData     (outData),
        .outValid    (outValid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct { int data; int due; } exp_t;
    exp_t q[$];
    int cyc = 0;
    int pass_cnt = 0, total_cnt = 0;
    int out_cnt = 0, last_data = 0;
    int ym = 0;          // model state, sample value scaled by 2^G
    int last_acc = -1000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: real-valued filter with floor rounding on the alpha*(x-y) term.
    task automatic model_push(input int x, input int c, input bit hp, input int due);
        longint prod;
        int lp, v;
        exp_t e;
        prod = (longint'(x) * (1 << G) - longint'(ym)) * longint'(c);
        ym = ym + int'(prod >>> CW);
        lp = ym >>> G;
        v = lp;
        if (hp) begin
            v = x - lp;
            if (v > (1 << (DW-1)) - 1) v = (1 << (DW-1)) - 1;
            if (v < -(1 << (DW-1))) v = -(1 << (DW-1));
        end
        e.data = v;
        e.due = due;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (outValid) begin
            out_cnt++;
            last_data = int'($signed(outData));
            if (q.size() == 0) begin
                chk("unexpected_outValid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("outData", last_data, e.data);
                chk("latency_cycle", cyc, e.due);
            end
        end
    end

    // Called at cycle start+1; inputs are held for exactly one cycle.
    task automatic pulse(input int x, input int c, input bit hp, input bit clr);
        bit acc;
        acc = (cyc - last_acc) >= LAT;
        inValid = 1'b1;
        inData = DW'(x);
        clearOverrun = clr;
        if (acc) begin
            coef = CW'(c);
            highpassSel = hp;
            last_acc = cyc;
`ifdef AUDIO_LOWPASS_HIGHPASS_EN
            model_push(x, c, hp, cyc + LAT);
`else
            model_push(x, c, 1'b0, cyc + LAT);
`endif
        end
        @(posedge clk); #1;
        inValid = 1'b0;
        clearOverrun = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        q.delete();
        ym = 0;
        last_acc = -1000;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin idle(1); n++; end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int oc, x, c, gap;
        bit hp;
        #1;
        do_reset();
        @(negedge clk);
        chk("rst_outData", int'(outData), 0);
        chk("rst_outValid", int'(outValid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        #1;

        // Step response with alpha = 0.5
        for (int i = 0; i < 3; i++) begin pulse(1024, 32, 0, 0); idle(19); end
        drain();
        chk("step_final", last_data, 896);

        // Negative input from reset
        do_reset();
        pulse(-1024, 63, 0, 0);
        drain(); idle(1);
        chk("neg_out", last_data, -1008);

        // Overrun: second sample three cycles later is dropped
        do_reset();
        pulse(1024, 32, 0, 0);
        @(negedge clk); chk("busy_c1", int'(busy), 1);
        idle(1);
        @(negedge clk); chk("busy_c2", int'(busy), 1);
        idle(1);
        pulse(100, 5, 0, 0);
        for (int k = 4; k <= 8; k++) begin
            @(negedge clk); chk("busy_mid", int'(busy), 1);
            idle(1);
        end
        @(negedge clk); chk("overrun_set", int'(overrun), 1);
        idle(1);
        chk("overrun_one_out", out_cnt >= 1 ? last_data : -1, 512);
        clearOverrun = 1'b1; idle(1); clearOverrun = 1'b0;
        @(negedge clk); chk("overrun_cleared", int'(overrun), 0);
        idle(1);
        pulse(1024, 32, 0, 0);
        idle(2);
        pulse(7, 1, 0, 1);
        @(negedge clk); chk("overrun_set_wins", int'(overrun), 1);
        idle(1);
        drain();

        // Reset during MUL step 2 aborts the sample
        do_reset();
        pulse(1024, 32, 0, 0);
        idle(3);
        oc = out_cnt;
        do_reset();
        idle(15);
        chk("abort_no_out", out_cnt, oc);
        pulse(1024, 32, 0, 0);
        drain(); idle(1);
        chk("after_abort", last_data, 512);

        // coef change during MUL is ignored
        do_reset();
        pulse(1024, 32, 0, 0);
        idle(1);
        coef = CW'(63);
        drain(); idle(1);
        chk("coef_snapshot", last_data, 512);

`ifdef AUDIO_LOWPASS_HIGHPASS_EN
        do_reset();
        pulse(1024, 32, 1, 0);
        drain(); idle(1);
        chk("hp_basic", last_data, 512);
        for (int i = 0; i < 6; i++) begin pulse(2047, 63, 0, 0); idle(LAT); end
        pulse(-2048, 1, 1, 0);
        drain(); idle(1);
        chk("hp_saturate", last_data, -2048);
`endif

        // Randomized traffic, including occasional drops
        do_reset();
        for (int i = 0; i < 60; i++) begin
            x = int'($urandom_range(0, 4095)) - 2048;
            c = int'($urandom_range(0, 63));
            hp = 1'($urandom_range(0, 1));
            gap = int'($urandom_range(0, 14));
            pulse(x, c, hp, 0);
            idle(gap);
        end
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
